reg_file: RTL and testbench
===========================

Name: reg_file

Overview:
- Integer register file for the RISC-V core: two asynchronous read ports (rs1, rs2) and one synchronous write port (rd).
- Depth 2^REG_MEM_DEPTH_POW entries, width 2^REG_DATA_WIDTH_POW bits. Defaults: 32 x 64-bit (RV64I).
- Register x0 is hardwired to zero.
- Sits between decode (source indices), writeback (rd and data) and the execute operand muxes.

Parameters:
- REG_DATA_WIDTH_POW, 6, log2 of register width; REG_DATA_WIDTH = 1 << REG_DATA_WIDTH_POW (derived localparam).
- REG_MEM_DEPTH_POW, 5, log2 of register count and width of the index ports; REG_MEM_DEPTH = 1 << REG_MEM_DEPTH_POW (derived localparam).

Ports:
- clk_in  input  1  clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high; clears all registers.
- rs1_in  input  REG_MEM_DEPTH_POW  read port 1 index.
- rs2_in  input  REG_MEM_DEPTH_POW  read port 2 index.
- rd_in  input  REG_MEM_DEPTH_POW  write index.
- data_write  input  REG_DATA_WIDTH  write data.
- write_en  input  1  write strobe for rd_in/data_write.
- reg_data1_out  output  REG_DATA_WIDTH  contents of register rs1_in.
- reg_data2_out  output  REG_DATA_WIDTH  contents of register rs2_in.

Behaviour:
- One clock (clk_in); reset is synchronous and active-high.
- Storage: REG_MEM_DEPTH x REG_DATA_WIDTH array.
  - Entry 0 is never written and always reads 0.
  - Implementations may omit physical storage for entry 0.
- Reads are combinational, zero latency.
  - reg_data1_out = (rs1_in == 0) ? 0 : mem[rs1_in]; reg_data2_out likewise with rs2_in.
  - Both ports are independent and may address the same register.
- Writes are synchronous.
  - At posedge clk_in with write_en=1, reset=0, rd_in!=0: mem[rd_in] <= data_write.
  - The new value is visible on the read ports immediately after that edge, i.e. in the following cycle.
- write_en=1 with rd_in==0: no state change.
- write_en=0: all registers hold. Outputs change only when the read indices change or after a write/reset edge.
- Same-cycle read of the register being written (no bypass): the output shows the old value until the edge.
- Reset:
  - At posedge clk_in with reset=1, every entry is cleared to 0.
  - After that edge, both outputs read 0 for every index until a new write.
  - Reset has priority over write_en; a write in a reset cycle is discarded.
  - No asynchronous clearing.
- Power-up contents before the first reset: undefined for entries 1..N-1. Entry 0 always reads 0.
- Index inputs are full-range (0..REG_MEM_DEPTH-1); no out-of-range case exists.

Optional Feature:
- Macro: REG_FILE_WRITE_BYPASS_EN.
- Defined:
  - Write-through forwarding on each read port.
  - If write_en=1, reset=0, rd_in!=0 and rsN_in==rd_in, then reg_dataN_out = data_write combinationally in the same cycle.
  - x0 still reads 0.
  - Reset cycle: no bypass.
- Not defined: pure array read as specified above; no forwarding.

Test Plan:
- Reset: write x5=0x1234 and x31=0xFFFF_FFFF_FFFF_FFFF, pulse reset for 1 cycle, then read rs1=5, rs2=31 -> both outputs 0.
- Write/read-back: write_en=1, rd=7, data=0xDEAD_BEEF_0000_0001; next cycle rs1=7, rs2=7 -> both outputs 0xDEAD_BEEF_0000_0001.
- x0 hardwired: write_en=1, rd=0, data=0xABCD; next cycle rs1=0, rs2=0 -> outputs 0. Same write with rd=1 makes x1 read 0xABCD.
- Hold: write x3=0x55; then 10 cycles with write_en=0 and random data_write/rd -> rs1=3 stays 0x55 every cycle.
- Priority and overwrite: reset=1 with write_en=1, rd=4, data=0x99 -> x4 reads 0 afterwards. Then write x4=0x1, then x4=0x2 on consecutive cycles -> reads 0x1, then 0x2.
- Same-cycle read/write: rs1=rd=9, write_en=1, data=0x77, old x9=0x11 -> reg_data1_out=0x11 before the edge without REG_FILE_WRITE_BYPASS_EN, 0x77 with it. Both builds read 0x77 after the edge.

Source files
------------

// File: rtl/reg_file.sv
// rtl/reg_file.sv - integer register file, two async read ports, one sync write port
//
// Purpose: RISC-V integer register file. x0 reads as zero and has no storage.
// Optional: define REG_FILE_WRITE_BYPASS_EN to forward the write data to a read
// port that addresses the register being written in the same cycle.
//
// Ports:
//   clk_in         clock, all state changes on rising edge
//   reset          synchronous active-high clear of every register
//   rs1_in/rs2_in  read indices
//   rd_in          write index
//   data_write     write data
//   write_en       write strobe
//   reg_data1_out  contents of register rs1_in
//   reg_data2_out  contents of register rs2_in
module reg_file #(
  parameter int REG_DATA_WIDTH_POW = 6,
  parameter int REG_MEM_DEPTH_POW  = 5
) (
  input  logic                            clk_in,
  input  logic                            reset,
  input  logic [REG_MEM_DEPTH_POW-1:0]    rs1_in,
  input  logic [REG_MEM_DEPTH_POW-1:0]    rs2_in,
  input  logic [REG_MEM_DEPTH_POW-1:0]    rd_in,
  input  logic [(1<<REG_DATA_WIDTH_POW)-1:0] data_write,
  input  logic                            write_en,
  output logic [(1<<REG_DATA_WIDTH_POW)-1:0] reg_data1_out,
  output logic [(1<<REG_DATA_WIDTH_POW)-1:0] reg_data2_out
);

  localparam int REG_DATA_WIDTH = 1 << REG_DATA_WIDTH_POW;
  localparam int REG_MEM_DEPTH  = 1 << REG_MEM_DEPTH_POW;

  // Entry 0 has no storage; the array starts at index 1.
  logic [REG_DATA_WIDTH-1:0] mem_q [1:REG_MEM_DEPTH-1];
  logic [REG_DATA_WIDTH-1:0] mem_d [1:REG_MEM_DEPTH-1];

  // Write decode: only the entry matching rd_in takes the new data.
  always_comb begin
    mem_d = mem_q;
    for (int i = 1; i < REG_MEM_DEPTH; i++) begin
      if (write_en && (rd_in == REG_MEM_DEPTH_POW'(i))) begin
        mem_d[i] = data_write;
      end
    end
  end

  // Reset takes priority over any write in the same cycle.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      for (int i = 1; i < REG_MEM_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

`ifdef REG_FILE_WRITE_BYPASS_EN
  logic wr_fwd;
  assign wr_fwd = write_en && !reset && (rd_in != '0);
`endif

  always_comb begin
    reg_data1_out = '0;
    if (rs1_in != '0) begin
`ifdef REG_FILE_WRITE_BYPASS_EN
      if (wr_fwd && (rs1_in == rd_in)) begin
        reg_data1_out = data_write;
      end else begin
        reg_data1_out = mem_q[rs1_in];
      end
`else
      reg_data1_out = mem_q[rs1_in];
`endif
    end
  end

  always_comb begin
    reg_data2_out = '0;
    if (rs2_in != '0) begin
`ifdef REG_FILE_WRITE_BYPASS_EN
      if (wr_fwd && (rs2_in == rd_in)) begin
        reg_data2_out = data_write;
      end else begin
        reg_data2_out = mem_q[rs2_in];
      end
`else
      reg_data2_out = mem_q[rs2_in];
`endif
    end
  end

endmodule

// File: tb/tb_reg_file.sv
// tb/tb_reg_file.sv - self-checking bench for reg_file
module tb_reg_file;

`ifdef REG_FILE_WRITE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk_in = 1'b0;
  logic        reset = 1'b0;
  logic [4:0]  rs1_in = '0;
  logic [4:0]  rs2_in = '0;
  logic [4:0]  rd_in = '0;
  logic [63:0] data_write = '0;
  logic        write_en = 1'b0;
  logic [63:0] reg_data1_out;
  logic [63:0] reg_data2_out;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  bit [63:0] model [32];

  reg_file dut (
    .clk_in        (clk_in),
    .reset         (reset),
    .rs1_in        (rs1_in),
    .rs2_in        (rs2_in),
    .rd_in         (rd_in),
    .data_write    (data_write),
    .write_en      (write_en),
    .reg_data1_out (reg_data1_out),
    .reg_data2_out (reg_data2_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Architectural view: the register file is an array of 32 values, x0 is zero.
  always @(posedge clk_in) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) model[i] = 64'd0;
    end else if (write_en && rd_in != 5'd0) begin
      model[rd_in] = data_write;
    end
  end

  function automatic bit [63:0] expect_read(input logic [4:0] rs);
    if (rs == 5'd0) return 64'd0;
    if (BYP && write_en && !reset && rd_in != 5'd0 && rd_in == rs) return data_write;
    return model[rs];
  endfunction

  always @(negedge clk_in) begin
    if (cmp_en) begin
      check("model_rs1", reg_data1_out, expect_read(rs1_in));
      check("model_rs2", reg_data2_out, expect_read(rs2_in));
    end
  end

  // Drive one cycle of inputs just after the rising edge; return after the
  // falling edge so the caller can sample outputs mid-cycle.
  task automatic apply(input logic rst, input logic we, input logic [4:0] rd,
                       input logic [63:0] d, input logic [4:0] r1, input logic [4:0] r2);
    @(posedge clk_in);
    #1;
    reset = rst; write_en = we; rd_in = rd; data_write = d; rs1_in = r1; rs2_in = r2;
    @(negedge clk_in);
    #1;
  endtask

  initial begin
    // Reset clears everything.
    apply(1, 0, 0, 0, 0, 0);
    apply(0, 1, 5, 64'h1234, 0, 0);
    cmp_en = 1'b1;
    check("reset_x0_rs1", reg_data1_out, 64'd0);
    apply(0, 1, 31, 64'hFFFF_FFFF_FFFF_FFFF, 5, 31);
    check("x5_written", reg_data1_out, 64'h1234);
    apply(1, 0, 0, 0, 5, 31);
    apply(0, 0, 0, 0, 5, 31);
    check("reset_x5", reg_data1_out, 64'd0);
    check("reset_x31", reg_data2_out, 64'd0);

    // Write / read-back on both ports.
    apply(0, 1, 7, 64'hDEAD_BEEF_0000_0001, 0, 0);
    apply(0, 0, 0, 0, 7, 7);
    check("wr_rd_p1", reg_data1_out, 64'hDEAD_BEEF_0000_0001);
    check("wr_rd_p2", reg_data2_out, 64'hDEAD_BEEF_0000_0001);

    // x0 hardwired.
    apply(0, 1, 0, 64'hABCD, 0, 0);
    apply(0, 1, 1, 64'hABCD, 0, 0);
    check("x0_p1", reg_data1_out, 64'd0);
    check("x0_p2", reg_data2_out, 64'd0);
    apply(0, 0, 0, 0, 1, 0);
    check("x1_written", reg_data1_out, 64'hABCD);
    check("x0_after", reg_data2_out, 64'd0);

    // Hold with write_en low.
    apply(0, 1, 3, 64'h55, 0, 0);
    for (int i = 0; i < 10; i++) begin
      apply(0, 0, 5'($urandom_range(0, 31)), {$urandom, $urandom}, 3, 5'($urandom_range(0, 31)));
      check("hold_x3", reg_data1_out, 64'h55);
    end

    // Reset beats write; then back-to-back overwrite.
    apply(1, 1, 4, 64'h99, 4, 0);
    apply(0, 0, 0, 0, 4, 0);
    check("rst_prio_x4", reg_data1_out, 64'd0);
    apply(0, 1, 4, 64'h1, 0, 0);
    apply(0, 1, 4, 64'h2, 4, 0);
    check("overwrite_1", reg_data1_out, BYP ? 64'h2 : 64'h1);
    apply(0, 0, 0, 0, 4, 0);
    check("overwrite_2", reg_data1_out, 64'h2);

    // Same-cycle read of the register being written.
    apply(0, 1, 9, 64'h11, 0, 0);
    apply(0, 1, 9, 64'h77, 9, 0);
    check("same_cyc", reg_data1_out, BYP ? 64'h77 : 64'h11);
    apply(0, 0, 0, 0, 9, 9);
    check("after_edge_p1", reg_data1_out, 64'h77);
    check("after_edge_p2", reg_data2_out, 64'h77);

    // Bypass must not apply in a reset cycle; x9 still holds 0x77 before the edge.
    apply(1, 1, 9, 64'hF0F0, 9, 9);
    check("rst_no_byp", reg_data1_out, 64'h77);
    apply(0, 0, 0, 0, 9, 9);
    check("rst_clear_x9", reg_data2_out, 64'd0);

    // Random traffic checked by the model only.
    for (int i = 0; i < 60; i++) begin
      apply(0, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), {$urandom, $urandom},
            5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
